// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX/MEM hazard inputs and stall/flush/freeze controls.
// HAZARD_CTRL_PERF_EN adds the LuCnt/FlushCnt/WaitCnt performance counters.
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 5
`ifdef HAZARD_CTRL_PERF_EN
    , parameter int CNT_W = 16
`endif
);
    logic [REG_W-1:0] Rs_ID;
    logic [REG_W-1:0] Rt_ID;
    logic             UsesRt_ID;
    logic             MemRead_EX;
    logic [REG_W-1:0] WriteReg_EX;
    logic             BranchTaken_EX;
    logic             MemReq_MEM;
    logic             MemAck_MEM;
    logic             Stall;
    logic             Flush_IF_ID;
    logic             Bubble_ID_EX;
    logic             Freeze;
    logic             MemErr;
    logic [1:0]       State;
`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] LuCnt;
    logic [CNT_W-1:0] FlushCnt;
    logic [CNT_W-1:0] WaitCnt;
`endif

    modport master (
        output Rs_ID, Rt_ID, UsesRt_ID, MemRead_EX, WriteReg_EX,
               BranchTaken_EX, MemReq_MEM, MemAck_MEM,
        input  Stall, Flush_IF_ID, Bubble_ID_EX, Freeze, MemErr, State
`ifdef HAZARD_CTRL_PERF_EN
        , input LuCnt, FlushCnt, WaitCnt
`endif
    );

    modport slave (
        input  Rs_ID, Rt_ID, UsesRt_ID, MemRead_EX, WriteReg_EX,
               BranchTaken_EX, MemReq_MEM, MemAck_MEM,
        output Stall, Flush_IF_ID, Bubble_ID_EX, Freeze, MemErr, State
`ifdef HAZARD_CTRL_PERF_EN
        , output LuCnt, FlushCnt, WaitCnt
`endif
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Mealy hazard controller for the 5-stage core: load-use stall, branch flush, memory-wait freeze with timeout.
// Optional perf counters enabled by defining HAZARD_CTRL_PERF_EN.
module hazard_stall_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4,
    parameter int CNT_W       = 16
) (
    input logic               Clk,
    input logic               Rst,
    hazard_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_t;

    localparam logic [TMR_W-1:0] TIMEOUT_VAL = TMR_W'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > (2**TMR_W) - 1 || CNT_W < 1) begin : g_param_err
        $error("hazard_stall_ctrl: MEM_TIMEOUT must fit 1..2^TMR_W-1 and CNT_W must be >= 1");
    end

    state_t           state, state_nx;
    logic [TMR_W-1:0] timer, timer_nx;
    logic             lu, hz_stall, hz_flush, hz_bubble;
    logic             stall_c, flush_c, bubble_c, freeze_c, err_c, illegal_c;

    assign lu = bus.MemRead_EX && (bus.WriteReg_EX != '0) &&
                ((bus.WriteReg_EX == bus.Rs_ID) ||
                 (bus.UsesRt_ID && (bus.WriteReg_EX == bus.Rt_ID)));

    // A taken branch kills the ID instruction, so its load-use dependency is irrelevant.
    assign hz_flush  = bus.BranchTaken_EX;
    assign hz_bubble = bus.BranchTaken_EX || lu;
    assign hz_stall  = !bus.BranchTaken_EX && lu;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= RUN;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        stall_c   = 1'b0;
        flush_c   = 1'b0;
        bubble_c  = 1'b0;
        freeze_c  = 1'b0;
        err_c     = 1'b0;
        illegal_c = 1'b0;
        case (state)
            RUN: begin
                if (bus.MemReq_MEM && !bus.MemAck_MEM) begin
                    freeze_c = 1'b1;
                    state_nx = MEM_WAIT;
                    timer_nx = TMR_W'(1);
                end else begin
                    stall_c  = hz_stall;
                    flush_c  = hz_flush;
                    bubble_c = hz_bubble;
                end
            end
            MEM_WAIT: begin
                if (bus.MemAck_MEM) begin
                    stall_c  = hz_stall;
                    flush_c  = hz_flush;
                    bubble_c = hz_bubble;
                    state_nx = RUN;
                    timer_nx = '0;
                end else if (timer >= TIMEOUT_VAL) begin
                    freeze_c = 1'b1;
                    state_nx = ERR;
                end else begin
                    // timer < TIMEOUT_VAL <= all-ones, so the increment cannot wrap
                    freeze_c = 1'b1;
                    timer_nx = timer + TMR_W'(1);
                end
            end
            ERR: begin
                freeze_c = 1'b1;
                err_c    = 1'b1;
            end
            default: begin
                illegal_c = 1'b1;
                state_nx  = RUN;
                timer_nx  = '0;
            end
        endcase
    end

    assign bus.Stall        = Rst && stall_c;
    assign bus.Flush_IF_ID  = Rst && flush_c;
    assign bus.Bubble_ID_EX = Rst && bubble_c;
    assign bus.Freeze       = Rst && freeze_c;
    assign bus.MemErr       = Rst && err_c;
    assign bus.State        = (Rst && !illegal_c) ? state : 2'b00;

`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] lu_cnt, flush_cnt, wait_cnt;
    logic             wait_evt;

    assign wait_evt = freeze_c && (state == MEM_WAIT);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            lu_cnt    <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (stall_c && lu_cnt != '1)     lu_cnt    <= lu_cnt + CNT_W'(1);
            if (flush_c && flush_cnt != '1)  flush_cnt <= flush_cnt + CNT_W'(1);
            if (wait_evt && wait_cnt != '1)  wait_cnt  <= wait_cnt + CNT_W'(1);
        end
    end

    assign bus.LuCnt    = Rst ? lu_cnt    : '0;
    assign bus.FlushCnt = Rst ? flush_cnt : '0;
    assign bus.WaitCnt  = Rst ? wait_cnt  : '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: per-cycle behavioural model plus directed literal checks.
module tb_hazard_stall_ctrl;

    localparam int REG_W       = 5;
    localparam int MEM_TIMEOUT = 15;
    localparam int TMR_W       = 4;
    localparam int CNT_W       = 2;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    hazard_stall_ctrl_if #(
        .REG_W(REG_W)
`ifdef HAZARD_CTRL_PERF_EN
        , .CNT_W(CNT_W)
`endif
    ) bus ();

    hazard_stall_ctrl #(
        .REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(TMR_W), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 running, 1 waiting on memory, 2 timed out.  waited = unacked wait cycles so far.
    int m_mode = 0, m_waited = 0, n_mode = 0, n_waited = 0;
    int m_lu = 0, m_fl = 0, m_wt = 0, n_lu = 0, n_fl = 0, n_wt = 0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    always @(negedge Clk) begin
        int e_st, e_fl, e_bu, e_fz, e_er, e_state;
        bit load_use;
        e_st = 0; e_fl = 0; e_bu = 0; e_fz = 0; e_er = 0; e_state = 0;
        n_mode = m_mode; n_waited = m_waited;
        n_lu = m_lu; n_fl = m_fl; n_wt = m_wt;
        load_use = bus.MemRead_EX && bus.WriteReg_EX != 0 &&
                   (bus.WriteReg_EX == bus.Rs_ID ||
                    (bus.UsesRt_ID && bus.WriteReg_EX == bus.Rt_ID));
        if (!Rst) begin
            n_mode = 0; n_waited = 0; n_lu = 0; n_fl = 0; n_wt = 0;
        end else begin
            bit hazard_ok;
            e_state   = m_mode;
            hazard_ok = 0;
            if (m_mode == 2) begin
                e_fz = 1; e_er = 1;
            end else if (m_mode == 0 && bus.MemReq_MEM && !bus.MemAck_MEM) begin
                e_fz = 1; n_mode = 1; n_waited = 1;
            end else if (m_mode == 1 && !bus.MemAck_MEM) begin
                e_fz = 1;
                n_wt = sat_inc(m_wt);
                if (m_waited >= MEM_TIMEOUT) n_mode = 2;
                else n_waited = m_waited + 1;
            end else begin
                hazard_ok = 1;
                n_mode = 0; n_waited = 0;
            end
            if (hazard_ok) begin
                if (bus.BranchTaken_EX) begin
                    e_fl = 1; e_bu = 1; n_fl = sat_inc(m_fl);
                end else if (load_use) begin
                    e_st = 1; e_bu = 1; n_lu = sat_inc(m_lu);
                end
            end
        end
        check("stall",  int'(bus.Stall),        e_st);
        check("flush",  int'(bus.Flush_IF_ID),  e_fl);
        check("bubble", int'(bus.Bubble_ID_EX), e_bu);
        check("freeze", int'(bus.Freeze),       e_fz);
        check("memerr", int'(bus.MemErr),       e_er);
        check("state",  int'(bus.State),        e_state);
`ifdef HAZARD_CTRL_PERF_EN
        check("lucnt",    int'(bus.LuCnt),    Rst ? m_lu : 0);
        check("flushcnt", int'(bus.FlushCnt), Rst ? m_fl : 0);
        check("waitcnt",  int'(bus.WaitCnt),  Rst ? m_wt : 0);
`endif
    end

    always @(posedge Clk) begin
        m_mode = n_mode; m_waited = n_waited;
        m_lu = n_lu; m_fl = n_fl; m_wt = n_wt;
    end

    // ---------------- directed stimulus ----------------
    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input bit mr, input int wr, input int rs, input int rt,
                         input bit urt, input bit br, input bit req, input bit ack);
        bus.MemRead_EX     = mr;
        bus.WriteReg_EX    = REG_W'(wr);
        bus.Rs_ID          = REG_W'(rs);
        bus.Rt_ID          = REG_W'(rt);
        bus.UsesRt_ID      = urt;
        bus.BranchTaken_EX = br;
        bus.MemReq_MEM     = req;
        bus.MemAck_MEM     = ack;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle();
        // reset with inputs toggling: everything held at 0
        Rst = 1'b0;
        cycle();
        drive(1, 8, 8, 0, 0, 1, 1, 0);
        #1;
        check("rst_stall",  int'(bus.Stall),  0);
        check("rst_freeze", int'(bus.Freeze), 0);
        check("rst_flush",  int'(bus.Flush_IF_ID), 0);
        cycle();
        idle();
        Rst = 1'b1;
        #1;
        check("post_rst_state", int'(bus.State),  0);
        check("post_rst_stall", int'(bus.Stall),  0);

        // load-use on rs, one bubble only
        cycle(); drive(1, 8, 8, 0, 0, 0, 0, 0); #1;
        check("lu_rs_stall",  int'(bus.Stall), 1);
        check("lu_rs_bubble", int'(bus.Bubble_ID_EX), 1);
        cycle(); drive(0, 0, 9, 0, 0, 0, 0, 0); #1;
        check("lu_rs_after", int'(bus.Stall), 0);
        // r0 never hazards
        cycle(); drive(1, 0, 0, 0, 0, 0, 0, 0); #1;
        check("lu_r0", int'(bus.Stall), 0);
        // rt dependency only when rt is read
        cycle(); drive(1, 5, 3, 5, 1, 0, 0, 0); #1;
        check("lu_rt", int'(bus.Stall), 1);
        cycle(); drive(1, 5, 3, 5, 0, 0, 0, 0); #1;
        check("lu_rt_unused", int'(bus.Stall), 0);

        // taken branch beats load-use
        cycle(); drive(1, 8, 8, 0, 0, 1, 0, 0); #1;
        check("br_flush",  int'(bus.Flush_IF_ID), 1);
        check("br_bubble", int'(bus.Bubble_ID_EX), 1);
        check("br_stall",  int'(bus.Stall), 0);
        cycle(); idle(); #1;
        check("br_after", int'(bus.Flush_IF_ID), 0);

        // req and ack same cycle: no freeze
        cycle(); drive(0, 0, 0, 0, 0, 0, 1, 1); #1;
        check("req_ack_same", int'(bus.Freeze), 0);

        // three unacked cycles then ack (branch seen on the ack cycle)
        cycle(); drive(0, 0, 0, 0, 0, 0, 1, 0); #1;
        check("mw_c1_freeze", int'(bus.Freeze), 1);
        check("mw_c1_state",  int'(bus.State), 0);
        cycle(); #1;
        check("mw_c2_state", int'(bus.State), 1);
        cycle(); #1;
        check("mw_c3_freeze", int'(bus.Freeze), 1);
        cycle(); drive(0, 0, 0, 0, 0, 1, 1, 1); #1;
        check("mw_ack_freeze", int'(bus.Freeze), 0);
        check("mw_ack_state",  int'(bus.State), 1);
        check("mw_ack_flush",  int'(bus.Flush_IF_ID), 1);
        cycle(); idle(); #1;
        check("mw_back_run", int'(bus.State), 0);

        // timeout: 1 + MEM_TIMEOUT frozen cycles, then ERR
        cycle(); drive(0, 0, 0, 0, 0, 0, 1, 0); #1;
        check("to_first", int'(bus.Freeze), 1);
        for (int i = 1; i <= MEM_TIMEOUT; i++) begin
            cycle(); #1;
            check("to_wait_state", int'(bus.State), 1);
            check("to_wait_err",   int'(bus.MemErr), 0);
        end
        cycle(); #1;
        check("to_err_state",  int'(bus.State), 2);
        check("to_err_memerr", int'(bus.MemErr), 1);
        cycle(); drive(1, 8, 8, 0, 0, 1, 0, 1); #1;
        check("err_sticky", int'(bus.MemErr), 1);
        check("err_freeze", int'(bus.Freeze), 1);
        check("err_noflush", int'(bus.Flush_IF_ID), 0);
        Rst = 1'b0; #1;
        check("err_rst_freeze", int'(bus.Freeze), 0);
        cycle(); idle(); Rst = 1'b1; #1;
        check("err_rst_state", int'(bus.State), 0);

        // reset in the middle of a memory wait abandons it
        cycle(); drive(0, 0, 0, 0, 0, 0, 1, 0);
        cycle(); #1;
        check("mid_wait_state", int'(bus.State), 1);
        Rst = 1'b0;
        cycle(); idle(); Rst = 1'b1; #1;
        check("mid_rst_state",  int'(bus.State), 0);
        check("mid_rst_memerr", int'(bus.MemErr), 0);

`ifdef HAZARD_CTRL_PERF_EN
        // counters from a fresh reset: 2 LU, 1 flush, 3 wait cycles
        Rst = 1'b0; cycle(); Rst = 1'b1;
        drive(1, 8, 8, 0, 0, 0, 0, 0); cycle(); cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 0); cycle(); cycle(); cycle(); cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 1); cycle();
        idle(); #1;
        check("perf_lu",    int'(bus.LuCnt), 2);
        check("perf_flush", int'(bus.FlushCnt), 1);
        check("perf_wait",  int'(bus.WaitCnt), 3);
        drive(0, 0, 0, 0, 0, 0, 1, 0); cycle(); cycle(); cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 1); cycle();
        idle(); #1;
        check("perf_wait_sat", int'(bus.WaitCnt), 3);
`endif

        cycle(); cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
